seq_divider: RTL and testbench

//  Iterative 32-bit integer divider for the CPU's DIV/DIVU instructions.

---
 rtl/seq_divider.sv | 95 +++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per falling clock edge.
// Define DIV_FAST_ZERO_EN to skip the iteration phase when the divisor is zero.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
`ifdef DIV_FAST_ZERO_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] dvd, dsr, q, q_fix, r_mag, r_fix;
    logic [WIDTH:0] rem;
    logic [WIDTH+1:0] diff;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r, zero;
    always_ff @(negedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? ((FAST_ZERO && divisor == '0) ? FINISH : RUN) : IDLE;
            RUN:     state_n = (cnt == CW'(WIDTH - 1)) ? FINISH : RUN;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // the extra guard bit keeps the borrow exact; rem[WIDTH] stays 0 between steps
    assign diff  = {rem, dvd[WIDTH-1]} - {2'b00, dsr};
    assign q_fix = neg_q ? -q : q;
    // with the fast path the untouched magnitude is still sitting in dvd
    assign r_mag = (FAST_ZERO && zero) ? dvd : rem[WIDTH-1:0];
    assign r_fix = neg_r ? -r_mag : r_mag;
    always_ff @(negedge clk) begin
        if (reset) begin
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            q           <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvd         <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    dsr         <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                    neg_q       <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r       <= is_signed && dividend[WIDTH-1];
                    zero        <= divisor == '0;
                    rem         <= '0;
                    q           <= '0;
                    cnt         <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                RUN: begin
                    rem <= diff[WIDTH+1] ? {rem[WIDTH-1:0], dvd[WIDTH-1]} : diff[WIDTH:0];
                    q   <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
                    dvd <= dvd << 1;
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    quotient    <= zero ? '1 : q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= zero;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divisions against an arithmetic reference model.
module tb_seq_divider;
    logic        clk, reset, start, is_signed;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        busy, done, div_by_zero;
    int          errors = 0, checks = 0, edge_n = 0, lat;
    logic [31:0] eq, er;
    logic        ez;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z = (b == 32'd0);
        if (z) begin
            q = '1;
            r = a;
        end else if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_FAST_ZERO_EN
        return (b == 32'd0) ? 2 : 34;
`else
        return 34;
`endif
    endfunction

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        edge_n = 1;
        @(posedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("done_after_accept", 32'(done), 32'd0);
    endtask

    task automatic wait_done(output int l);
        while (done !== 1'b1 && edge_n < 100) begin
            @(negedge clk);
            edge_n++;
            @(posedge clk);
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL timeout observed=done_low expected=done_high");
        end
        l = edge_n;
    endtask

    task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        ref_div(s, a, b, eq, er, ez);
        launch(s, a, b);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(b)));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 32'd5; divisor = 32'd1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        chk("rst_start_ignored", 32'(busy), 32'd0);

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        chk("t1_q_const", quotient, 32'd14);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("t2_q_const", quotient, 32'hFFFF_FFFD);
        chk("t2_r_const", remainder, 32'hFFFF_FFFF);
        do_op("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        chk("t2u_q_const", quotient, 32'h7FFF_FFFC);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t3_q_const", quotient, 32'h8000_0000);
        do_op("div_zero", 1'b1, 32'hFFFF_FFFB, 32'd0);
        chk("t4_r_const", remainder, 32'hFFFF_FFFB);
        do_op("divu_zero", 1'b0, 32'h8000_0001, 32'd0);

        launch(1'b0, 32'd1000, 32'd3);
        repeat (8) begin
            @(negedge clk);
            edge_n++;
            @(posedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        do_op("after_rst_9_4", 1'b0, 32'd9, 32'd4);

        ref_div(1'b0, 32'd50, 32'd5, eq, er, ez);
        launch(1'b0, 32'd50, 32'd5);
        repeat (3) begin
            @(negedge clk);
            edge_n++;
            @(posedge clk);
        end
        dividend = 32'd7; divisor = 32'd7; start = 1'b1;
        wait_done(lat);
        chk("busy_start_lat", 32'(lat), 32'd34);
        chk("busy_start_q", quotient, eq);
        chk("busy_start_r", remainder, er);
        @(negedge clk);
        edge_n = 1;
        @(posedge clk);
        start = 1'b0;
        chk("held_accept_busy", 32'(busy), 32'd1);
        chk("held_accept_done", 32'(done), 32'd0);
        wait_done(lat);
        chk("held_lat", 32'(lat), 32'd34);
        chk("held_q", quotient, 32'd1);
        chk("held_r", remainder, 32'd0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op("rand", s, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
